// File: rtl/rv32i_types_pkg.sv
// Shared decode/execute types for the out-of-order core: the issue bundle
// carried from decode to execute and the scalar FU to FU-index mapping.
package rv32i_types_pkg;

    typedef enum logic [2:0] {
        SFU_ALU    = 3'd0,
        SFU_BRANCH = 3'd1,
        SFU_CSR    = 3'd2,
        SFU_MUL    = 3'd3,
        SFU_DIV    = 3'd4,
        SFU_LOAD   = 3'd5,
        SFU_STORE  = 3'd6,
        SFU_NONE   = 3'd7
    } scalar_fu_t;

    // Index into the fu_busy / stall vectors.
    typedef enum logic [1:0] {
        ARITH_FU = 2'd0,
        MULT_FU  = 2'd1,
        DIV_FU   = 2'd2,
        LSU_FU   = 2'd3
    } fu_idx_t;

    localparam int NUM_FU = 4;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } prediction_t;

    typedef struct packed {
        logic       reg_write;
        logic [4:0] rd;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
    } control_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic [31:0] immediate;
        logic [31:0] port_a;
        logic [31:0] port_b;
        logic [31:0] store_data;
        logic [6:0]  opcode;
        scalar_fu_t  sfu_type;
        logic        halt_instr;
        prediction_t prediction;
        control_t    control;
    } issue_bundle_t;

    // Branches, CSR ops and no-op bundles all execute on the arithmetic unit.
    function automatic fu_idx_t sfu_to_fu_idx(input scalar_fu_t sfu);
        fu_idx_t idx;
        case (sfu)
            SFU_MUL:             idx = MULT_FU;
            SFU_DIV:             idx = DIV_FU;
            SFU_LOAD, SFU_STORE: idx = LSU_FU;
            default:             idx = ARITH_FU;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/ooo_issue_fifo_mem.sv
// Bundle storage for the issue buffer: DEPTH registers, one synchronous
// write port and one asynchronous read port. Contents are never reset.
module ooo_issue_fifo_mem
    import rv32i_types_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  issue_bundle_t    wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output issue_bundle_t    rd_data
);

    issue_bundle_t mem [DEPTH];

    // Write the incoming bundle into its slot on an accepted push.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ooo_issue_buffer.sv
// In-order issue buffer between decode and execute. Holds up to DEPTH
// bundles and issues the head when its functional unit is free; reports
// per-FU stalls back to decode and handles flush and halt draining.
module ooo_issue_buffer
    import rv32i_types_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               dec_valid,
    output logic               dec_ready,
    input  issue_bundle_t      dec_bundle,
    input  logic [NUM_FU-1:0]  fu_busy,
    input  logic               flush,
    output logic               ex_valid,
    output issue_bundle_t      ex_bundle,
    output logic               stall_arith,
    output logic               stall_multiply,
    output logic               stall_divide,
    output logic               stall_loadstore,
    output logic [PTR_W:0]     count,
    output logic               halted
);

    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             halted_q;

    logic             empty;
    logic             full;
    logic             issue;
    logic             push;
    logic             head_blocked;
    fu_idx_t          head_fu;
    issue_bundle_t    head;

    ooo_issue_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .CLK     (CLK),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (dec_bundle),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign head_fu = sfu_to_fu_idx(head.sfu_type);

    // Flush wins over everything, so neither issue nor push may fire with it.
    assign issue        = !empty && !fu_busy[head_fu] && !halted_q && !flush;
    assign dec_ready    = (!full || issue) && !flush;
    assign push         = dec_valid && dec_ready;
    assign head_blocked = !empty && !halted_q && fu_busy[head_fu];

    assign ex_valid        = issue;
    assign ex_bundle       = head;
    assign stall_arith     = head_blocked && (head_fu == ARITH_FU);
    assign stall_multiply  = head_blocked && (head_fu == MULT_FU);
    assign stall_divide    = head_blocked && (head_fu == DIV_FU);
    assign stall_loadstore = head_blocked && (head_fu == LSU_FU);
    assign count           = count_q;
    assign halted          = halted_q;

    // Pointer, occupancy and halt bookkeeping; flush returns to the reset image.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                if (head.halt_instr) begin
                    halted_q <= 1'b1;
                end
            end
            if (push && !issue) begin
                count_q <= count_q + CNT_W'(1);
            end else if (issue && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Guard against overflow and inconsistent stall reporting.
    always @(posedge CLK) begin
        if (!RST) begin
            assert (!(push && full && !issue)) else $error("push into full buffer");
            assert (count_q <= CNT_W'(DEPTH)) else $error("occupancy above DEPTH");
            assert ($onehot0({stall_loadstore, stall_divide, stall_multiply, stall_arith}))
                else $error("more than one stall line asserted");
        end
    end

endmodule

// File: tb/tb_ooo_issue_buffer.sv
// Self-checking bench for ooo_issue_buffer: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_ooo_issue_buffer;
    import rv32i_types_pkg::*;

    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          dec_valid;
    logic          dec_ready;
    issue_bundle_t dec_bundle;
    logic [3:0]    fu_busy;
    logic          flush;
    logic          ex_valid;
    issue_bundle_t ex_bundle;
    logic          stall_arith, stall_multiply, stall_divide, stall_loadstore;
    logic [2:0]    count;
    logic          halted;

    int errors = 0;
    int checks = 0;

    issue_bundle_t exp_q[$];
    bit            halted_m = 1'b0;

    ooo_issue_buffer #(.DEPTH(DEPTH)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_bundle      (dec_bundle),
        .fu_busy         (fu_busy),
        .flush           (flush),
        .ex_valid        (ex_valid),
        .ex_bundle       (ex_bundle),
        .stall_arith     (stall_arith),
        .stall_multiply  (stall_multiply),
        .stall_divide    (stall_divide),
        .stall_loadstore (stall_loadstore),
        .count           (count),
        .halted          (halted)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which unit a bundle needs, straight from the FU class of the op.
    function automatic int ref_fu(input scalar_fu_t s);
        if (s == SFU_MUL) return 1;
        if (s == SFU_DIV) return 2;
        if (s == SFU_LOAD || s == SFU_STORE) return 3;
        return 0;
    endfunction

    function automatic issue_bundle_t mk(input logic [31:0] pc, input scalar_fu_t sfu, input logic halt);
        issue_bundle_t b;
        logic [31:0]   r;
        b.pc                = pc;
        b.pc4               = pc + 32'd4;
        b.instr             = $urandom;
        b.immediate         = $urandom;
        b.port_a            = $urandom;
        b.port_b            = $urandom;
        b.store_data        = $urandom;
        r                   = $urandom;
        b.opcode            = r[6:0];
        b.sfu_type          = sfu;
        b.halt_instr        = halt;
        b.prediction.taken  = r[7];
        b.prediction.target = $urandom;
        r                   = $urandom;
        b.control           = r[10:0];
        return b;
    endfunction

    // Reference model + scoreboard: checks outputs between edges, then
    // advances the model to what the coming edge must produce.
    always @(negedge CLK) begin
        if (RST) begin
            exp_q.delete();
            halted_m = 1'b0;
        end else begin
            bit         empty, blocked, issue_m, ready_m;
            int         f;
            logic [3:0] exp_st;
            empty   = (exp_q.size() == 0);
            f       = empty ? 0 : ref_fu(exp_q[0].sfu_type);
            blocked = !empty && !halted_m && fu_busy[f];
            issue_m = !empty && !fu_busy[f] && !halted_m && !flush;
            ready_m = !flush && ((exp_q.size() < DEPTH) || issue_m);
            exp_st  = blocked ? 4'(1 << f) : 4'b0000;
            chk("ex_valid", 32'(ex_valid), 32'(issue_m));
            chk("dec_ready", 32'(dec_ready), 32'(ready_m));
            chk("count", 32'(count), 32'(exp_q.size()));
            chk("halted", 32'(halted), 32'(halted_m));
            chk("stalls", 32'({stall_loadstore, stall_divide, stall_multiply, stall_arith}), 32'(exp_st));
            if (ex_valid) begin
                checks++;
                if (empty) begin
                    errors++;
                    $display("FAIL issue_order: issued pc %0h with nothing expected", ex_bundle.pc);
                end else if (ex_bundle !== exp_q[0]) begin
                    errors++;
                    $display("FAIL issue_bundle: got pc %0h expected pc %0h", ex_bundle.pc, exp_q[0].pc);
                end
            end
            if (flush) begin
                exp_q.delete();
                halted_m = 1'b0;
            end else begin
                if (issue_m) begin
                    if (exp_q[0].halt_instr) halted_m = 1'b1;
                    void'(exp_q.pop_front());
                end
                if (dec_valid && ready_m) exp_q.push_back(dec_bundle);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input issue_bundle_t b, input logic [3:0] busy, input logic fl);
        dec_valid  = v;
        dec_bundle = b;
        fu_busy    = busy;
        flush      = fl;
    endtask

    task automatic mid();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        drive(1'b0, mk(32'h0, SFU_ALU, 1'b0), 4'h0, 1'b0);
        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(dec_ready), 32'd1);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        #1 RST = 1'b0;

        // Fill/drain with all FUs free.
        for (int i = 0; i < 4; i++) begin
            step(); drive(1'b1, mk(32'h100 + 32'(4 * i), SFU_ALU, 1'b0), 4'h0, 1'b0);
        end
        step(); drive(1'b0, mk(32'h0, SFU_ALU, 1'b0), 4'h0, 1'b0);
        step(); step();
        mid(); chk("drain_count", 32'(count), 32'd0);

        // Fill behind a busy arith unit, then push and issue together at full.
        for (int i = 0; i < 4; i++) begin
            step(); drive(1'b1, mk(32'h100 + 32'(4 * i), SFU_ALU, 1'b0), 4'b0001, 1'b0);
        end
        step(); drive(1'b0, mk(32'h0, SFU_ALU, 1'b0), 4'b0001, 1'b0);
        mid();
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(dec_ready), 32'd0);
        chk("full_stall_arith", 32'(stall_arith), 32'd1);
        step(); drive(1'b1, mk(32'h200, SFU_ALU, 1'b0), 4'b0000, 1'b0);
        mid();
        chk("full_issue", 32'(ex_valid), 32'd1);
        chk("full_issue_pc", ex_bundle.pc, 32'h100);
        chk("full_ready_issue", 32'(dec_ready), 32'd1);
        step(); drive(1'b0, mk(32'h0, SFU_ALU, 1'b0), 4'b0000, 1'b0);
        mid(); chk("full_count_kept", 32'(count), 32'd4);
        repeat (5) step();

        // Divide-unit stall.
        step(); drive(1'b1, mk(32'h300, SFU_DIV, 1'b0), 4'b0100, 1'b0);
        step(); drive(1'b0, mk(32'h0, SFU_ALU, 1'b0), 4'b0100, 1'b0);
        mid();
        chk("div_stall", 32'(stall_divide), 32'd1);
        chk("div_other_stalls", 32'({stall_loadstore, stall_multiply, stall_arith}), 32'd0);
        chk("div_no_issue", 32'(ex_valid), 32'd0);
        step(); drive(1'b0, mk(32'h0, SFU_ALU, 1'b0), 4'b0000, 1'b0);
        mid();
        chk("div_issue", 32'(ex_valid), 32'd1);
        chk("div_issue_pc", ex_bundle.pc, 32'h300);
        step();

        // Flush colliding with push and free FUs.
        for (int i = 0; i < 3; i++) begin
            step(); drive(1'b1, mk(32'h400 + 32'(4 * i), SFU_LOAD, 1'b0), 4'hF, 1'b0);
        end
        step(); drive(1'b1, mk(32'h500, SFU_ALU, 1'b0), 4'h0, 1'b1);
        mid();
        chk("flush_no_issue", 32'(ex_valid), 32'd0);
        chk("flush_not_ready", 32'(dec_ready), 32'd0);
        step(); drive(1'b0, mk(32'h0, SFU_ALU, 1'b0), 4'h0, 1'b0);
        mid();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_ex_valid", 32'(ex_valid), 32'd0);
        step(); drive(1'b1, mk(32'h600, SFU_ALU, 1'b0), 4'h0, 1'b0);
        step(); drive(1'b0, mk(32'h0, SFU_ALU, 1'b0), 4'h0, 1'b0);
        mid(); chk("post_flush_pc", ex_bundle.pc, 32'h600);
        step();

        // Halt then two more pushes, released by flush.
        step(); drive(1'b1, mk(32'h700, SFU_ALU, 1'b1), 4'h0, 1'b0);
        step(); drive(1'b1, mk(32'h704, SFU_ALU, 1'b0), 4'h0, 1'b0);
        step(); drive(1'b1, mk(32'h708, SFU_MUL, 1'b0), 4'h0, 1'b0);
        step(); drive(1'b0, mk(32'h0, SFU_ALU, 1'b0), 4'h0, 1'b0);
        mid();
        chk("halt_set", 32'(halted), 32'd1);
        chk("halt_no_issue", 32'(ex_valid), 32'd0);
        chk("halt_count", 32'(count), 32'd2);
        step(); drive(1'b0, mk(32'h0, SFU_ALU, 1'b0), 4'h0, 1'b1);
        step(); drive(1'b0, mk(32'h0, SFU_ALU, 1'b0), 4'h0, 1'b0);
        mid();
        chk("halt_cleared", 32'(halted), 32'd0);
        chk("halt_flush_count", 32'(count), 32'd0);

        // Asynchronous reset between edges.
        step(); drive(1'b1, mk(32'h800, SFU_STORE, 1'b0), 4'hF, 1'b0);
        step(); drive(1'b1, mk(32'h804, SFU_ALU, 1'b0), 4'hF, 1'b0);
        step(); drive(1'b0, mk(32'h0, SFU_ALU, 1'b0), 4'h0, 1'b0);
        chk("pre_reset_count", 32'(count), 32'd2);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("async_rst_halted", 32'(halted), 32'd0);
        @(negedge CLK);
        #2 RST = 1'b0;

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] busy;
            step();
            busy = 4'($urandom) & 4'($urandom) & 4'($urandom);
            drive($urandom_range(0, 3) != 0,
                  mk($urandom, scalar_fu_t'($urandom_range(0, 7)), $urandom_range(0, 15) == 0),
                  busy,
                  (halted_m && $urandom_range(0, 3) == 0) || ($urandom_range(0, 40) == 0));
        end
        step(); drive(1'b0, mk(32'h0, SFU_ALU, 1'b0), 4'h0, 1'b0);
        repeat (8) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ooo_issue_buffer.md
Name: ooo_issue_buffer

Overview:
In-order issue buffer between the decode stage and the execute stage of the out-of-order core. It holds decoded instruction bundles in a small FIFO and issues the head bundle to execute only when the target functional unit (FU) is free. It drives the per-FU stall lines (arith/mult/div/loadstore) that decode forwards across the decode/execute interface. It also handles pipeline flush and halt draining.

Parameters:
DEPTH, 4, number of bundle entries; must be a power of 2, ≥2.
PTR_W, $clog2(DEPTH), read/write pointer width (derived; do not override).

Ports:
CLK  input  1  core clock; all state updates on the rising edge.
RST  input  1  asynchronous, active-high reset.
dec_valid  input  1  decode presents a bundle.
dec_ready  output  1  buffer accepts; a push occurs when dec_valid && dec_ready.
dec_bundle  input  $bits(issue_bundle_t)  decoded bundle: pc, pc4, instr, immediate, port_a, port_b, store_data, opcode, sfu_type, halt_instr, prediction, control structs.
fu_busy  input  4  busy flags, bit order [3]=lsu, [2]=div, [1]=mult, [0]=arith.
flush  input  1  branch mispredict or exception redirect; discards all held bundles.
ex_valid  output  1  head bundle issued this cycle.
ex_bundle  output  $bits(issue_bundle_t)  head bundle contents, valid when ex_valid.
stall_arith, stall_multiply, stall_divide, stall_loadstore  output  1 each  head is blocked on that FU.
count  output  PTR_W+1  occupancy, 0..DEPTH.
halted  output  1  a halt instruction has issued; sticky until flush or reset.

Behaviour:
- Reset (async, RST=1): pointers=0, count=0, halted=0. ex_valid=0, all stalls=0, dec_ready=1. Entry storage is not reset. ex_bundle = entry[rd_ptr], don't-care.
- Storage: circular array of DEPTH entries. wr_ptr and rd_ptr are PTR_W bits and wrap modulo DEPTH. count is tracked separately, so full means count==DEPTH and empty means count==0.
- dec_ready = !full || issue. It is combinational and allows a same-cycle push while full if the head issues. dec_ready=0 while flush=1.
- Head FU is decoded from head.sfu_type via the package function sfu_to_fu_idx.
- issue = !empty && !fu_busy[fu_idx] && !halted && !flush. ex_valid = issue (combinational). ex_bundle reads directly from the head entry (zero-latency FWFT).
- stall_<fu> = !empty && !halted && fu_busy[fu_idx] && (fu_idx==<fu>). At most one stall line is asserted. All stall lines are 0 while empty.
- Pointer/count update per edge:
  - push only: wr_ptr+1, count+1.
  - issue only: rd_ptr+1, count-1.
  - push and issue together: both pointers advance, count unchanged. This is valid at full and, when count==1, at near-empty.
- No bypass: a bundle pushed in cycle N is issuable at the earliest in cycle N+1. An empty buffer gives 1-cycle decode-to-issue latency.
- Halt: when an issued bundle has halt_instr=1, halted is set the next cycle. Further issue is blocked. Pushes continue until full.
- Flush has priority over push and issue in the same cycle. On the next edge: rd_ptr=wr_ptr=0, count=0, halted=0. A concurrent dec_valid is dropped.
- Asserting RST mid-operation discards contents immediately, regardless of clock.
- Assertions: no push when full && !issue; count ≤ DEPTH; stall lines are one-hot-or-zero.

Decomposition:
- rv32i_types_pkg gets:
  - issue_bundle_t: packed struct of the decode→execute payload fields.
  - typedef fu_idx_t (2-bit enum ARITH_FU=0, MULT_FU=1, DIV_FU=2, LSU_FU=3).
  - function sfu_to_fu_idx(scalar_fu_t).
- Optional sub-module ooo_issue_fifo_mem: the DEPTH×bundle register array with write port and async read port. Control logic stays in ooo_issue_buffer.

Test Plan:
- Fill/drain: fu_busy=0, push 4 ARITH bundles with pc 0x100..0x10C back-to-back. Expected: each issues 1 cycle after its push, in order; count never exceeds 1; dec_ready stays 1.
- Full, simultaneous: fu_busy=4'b0001 (arith busy), push 4 ARITH bundles. Expected: count=4, dec_ready=0, stall_arith=1. Then clear fu_busy while dec_valid=1. Expected: pc 0x100 issues, the new bundle is accepted in the same cycle, count stays 4.
- Per-FU stall: head is DIV with fu_busy=4'b0100. Expected: stall_divide=1, other stalls 0, ex_valid=0. Drop busy → issues next cycle.
- Flush collision: count=3, assert flush together with dec_valid and free FUs. Expected: ex_valid=0 that cycle; next cycle count=0, pointers=0, no bundle issued.
- Halt: issue a bundle with halt_instr=1, then push 2 more. Expected: halted=1, ex_valid=0, count=2. Apply flush → halted=0, count=0.
- Reset mid-stream: assert RST asynchronously between edges with count=2. Expected: count=0, ex_valid=0, halted=0 immediately, before the next CLK edge.
